// File: rtl/bc_msg_sequencer.sv
// rtl/bc_msg_sequencer.sv - 1553B BC message sequencer between host buffers and the core tx/rx FIFOs
module bc_msg_sequencer #(
   parameter int TIMEOUT_CYC = 1400,
   parameter int TO_W        = 16,
   parameter int BUF_AW      = 5
) (
   input  logic              APB_CLK,
   input  logic              APB_RESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [15:0]       cmd_word,
   output logic [BUF_AW-1:0] tx_buf_addr,
   input  logic [15:0]       tx_buf_data,
   output logic              rx_buf_we,
   output logic [BUF_AW-1:0] rx_buf_addr,
   output logic [15:0]       rx_buf_wdata,
   output logic              done_valid,
   output logic [1:0]        done_code,
   output logic [15:0]       done_status,
   output logic [5:0]        done_rcvd,
   output logic              busy,
   output logic              core_tx_wr,
   input  logic              core_tx_unfull,
   output logic [23:0]       core_tx_data,
   output logic              core_rx_rd,
   input  logic              core_rx_unempty,
   input  logic [23:0]       core_rx_data
);

   typedef enum logic [2:0] {
      S_IDLE, S_SEND_CMD, S_LOAD, S_PUSH, S_WAIT_STAT, S_RECV, S_DONE
   } state_t;

   localparam logic [1:0] CODE_OK   = 2'd0;
   localparam logic [1:0] CODE_TO   = 2'd1;
   localparam logic [1:0] CODE_RXE  = 2'd2;
   localparam logic [1:0] CODE_PROT = 2'd3;

   state_t            state_q, state_d;
   logic [15:0]       cmd_q, cmd_d;
   logic [5:0]        n_q, n_d;
   logic [5:0]        idx_q, idx_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic [1:0]        code_q, code_d;
   logic [15:0]       status_q, status_d;
   logic [5:0]        rcvd_q, rcvd_d;

   logic              rx_err, rx_sync, timeout_hit, rx_unused;

   assign rx_err      = core_rx_data[17];
   assign rx_sync     = core_rx_data[16];
   assign rx_unused   = &{1'b0, core_rx_data[23:18]};
   assign timeout_hit = (cnt_q == TO_W'(TIMEOUT_CYC - 1));

   assign tx_buf_addr  = idx_q[BUF_AW-1:0];
   assign rx_buf_addr  = rcvd_q[BUF_AW-1:0];
   assign rx_buf_wdata = rx_buf_we ? core_rx_data[15:0] : 16'h0;
   assign done_code    = code_q;
   assign done_status  = status_q;
   assign done_rcvd    = rcvd_q;
   assign busy         = (state_q != S_IDLE);

   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      n_d          = n_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      code_d       = code_q;
      status_d     = status_q;
      rcvd_d       = rcvd_q;
      cmd_ready    = 1'b0;
      core_rx_rd   = 1'b0;
      core_tx_wr   = 1'b0;
      core_tx_data = 24'h0;
      rx_buf_we    = 1'b0;
      done_valid   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // stale words are flushed before a new command may start
            if (core_rx_unempty) begin
               core_rx_rd = 1'b1;
            end else begin
               cmd_ready = 1'b1;
               if (cmd_valid) begin
                  cmd_d    = cmd_word;
                  n_d      = (cmd_word[4:0] == 5'd0) ? 6'd32 : {1'b0, cmd_word[4:0]};
                  idx_d    = 6'd0;
                  code_d   = CODE_OK;
                  status_d = 16'h0;
                  rcvd_d   = 6'd0;
                  state_d  = S_SEND_CMD;
               end
            end
         end
         S_SEND_CMD: begin
            if (core_tx_unfull) begin
               core_tx_wr   = 1'b1;
               core_tx_data = {7'b0, 1'b1, cmd_q};
               cnt_d        = '0;
               state_d      = cmd_q[10] ? S_WAIT_STAT : S_LOAD;
            end
         end
         S_LOAD: state_d = S_PUSH;
         S_PUSH: begin
            if (core_tx_unfull) begin
               core_tx_wr   = 1'b1;
               core_tx_data = {7'b0, 1'b0, tx_buf_data};
               idx_d        = idx_q + 6'd1;
               cnt_d        = '0;
               state_d      = (idx_q == n_q - 6'd1) ? S_WAIT_STAT : S_LOAD;
            end
         end
         S_WAIT_STAT: begin
            if (core_rx_unempty) begin
               core_rx_rd = 1'b1;
               cnt_d      = '0;
               if (rx_err) begin
                  code_d  = CODE_RXE;
                  state_d = S_DONE;
               end else if (!rx_sync || core_rx_data[15:11] != cmd_q[15:11]) begin
                  code_d  = CODE_PROT;
                  state_d = S_DONE;
               end else begin
                  status_d = core_rx_data[15:0];
                  code_d   = CODE_OK;
                  state_d  = cmd_q[10] ? S_RECV : S_DONE;
               end
            end else if (timeout_hit) begin
               code_d  = CODE_TO;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RECV: begin
            if (core_rx_unempty) begin
               core_rx_rd = 1'b1;
               cnt_d      = '0;
               if (rx_err) begin
                  code_d  = CODE_RXE;
                  state_d = S_DONE;
               end else if (rx_sync) begin
                  code_d  = CODE_PROT;
                  state_d = S_DONE;
               end else begin
                  rx_buf_we = 1'b1;
                  rcvd_d    = rcvd_q + 6'd1;
                  if (rcvd_q + 6'd1 == n_q) begin
                     code_d  = CODE_OK;
                     state_d = S_DONE;
                  end
               end
            end else if (timeout_hit) begin
               code_d  = CODE_TO;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            done_valid = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // the core FIFOs and host see nothing while reset is held
      if (APB_RESET) begin
         cmd_ready    = 1'b0;
         core_rx_rd   = 1'b0;
         core_tx_wr   = 1'b0;
         core_tx_data = 24'h0;
         rx_buf_we    = 1'b0;
         done_valid   = 1'b0;
      end
   end

   always_ff @(posedge APB_CLK) begin
      if (APB_RESET) begin
         state_q  <= S_IDLE;
         cmd_q    <= 16'h0;
         n_q      <= 6'd0;
         idx_q    <= 6'd0;
         cnt_q    <= '0;
         code_q   <= 2'd0;
         status_q <= 16'h0;
         rcvd_q   <= 6'd0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         n_q      <= n_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         code_q   <= code_d;
         status_q <= status_d;
         rcvd_q   <= rcvd_d;
      end
   end

endmodule

// File: tb/tb_bc_msg_sequencer.sv
// tb/tb_bc_msg_sequencer.sv - scoreboard bench for bc_msg_sequencer with FIFO/buffer models
module tb_bc_msg_sequencer;
   localparam int TO = 60;

   typedef struct {
      logic [1:0]  code;
      logic [15:0] status;
      logic [5:0]  rcvd;
      int          leftover;
   } exp_t;

   logic        clk = 1'b0;
   logic        APB_RESET;
   logic        cmd_valid, cmd_ready;
   logic [15:0] cmd_word;
   logic [4:0]  tx_buf_addr;
   logic [15:0] tx_buf_data;
   logic        rx_buf_we;
   logic [4:0]  rx_buf_addr;
   logic [15:0] rx_buf_wdata;
   logic        done_valid;
   logic [1:0]  done_code;
   logic [15:0] done_status;
   logic [5:0]  done_rcvd;
   logic        busy;
   logic        core_tx_wr, core_tx_unfull;
   logic [23:0] core_tx_data;
   logic        core_rx_rd, core_rx_unempty;
   logic [23:0] core_rx_data;

   logic [15:0] mem [32];
   logic [23:0] rxq[$];
   logic [23:0] exp_tx[$];
   logic [20:0] exp_wr[$];
   exp_t        exp_done[$];

   int   checks = 0, failures = 0, cyc = 0, last_evt = 0, done_cnt = 0, stall_cnt = 0;
   logic pop_pend = 1'b0;
   logic [4:0] addr_smp = 5'd0;

   always #5 clk = ~clk;

   bc_msg_sequencer #(.TIMEOUT_CYC(TO), .TO_W(16), .BUF_AW(5)) dut (
      .APB_CLK(clk), .APB_RESET(APB_RESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_word(cmd_word),
      .tx_buf_addr(tx_buf_addr), .tx_buf_data(tx_buf_data),
      .rx_buf_we(rx_buf_we), .rx_buf_addr(rx_buf_addr), .rx_buf_wdata(rx_buf_wdata),
      .done_valid(done_valid), .done_code(done_code), .done_status(done_status),
      .done_rcvd(done_rcvd), .busy(busy),
      .core_tx_wr(core_tx_wr), .core_tx_unfull(core_tx_unfull), .core_tx_data(core_tx_data),
      .core_rx_rd(core_rx_rd), .core_rx_unempty(core_rx_unempty), .core_rx_data(core_rx_data)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void bound_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=no_event expected=event_within_bound (cycle %0d)", name, cyc);
   endfunction

   // core FIFO, host buffer and back-pressure models, updated just after each rising edge
   initial begin
      logic [23:0] tmp;
      core_tx_unfull = 1'b0; core_rx_unempty = 1'b0; core_rx_data = 24'h0; tx_buf_data = 16'h0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (pop_pend && rxq.size() != 0) tmp = rxq.pop_front();
         pop_pend    = 1'b0;
         tx_buf_data = mem[addr_smp];
         if (stall_cnt > 0) begin
            core_tx_unfull = 1'b0;
            stall_cnt--;
         end else begin
            core_tx_unfull = ($urandom_range(0, 3) != 0);
         end
         core_rx_unempty = (rxq.size() != 0);
         core_rx_data    = core_rx_unempty ? rxq[0] : 24'h0;
      end
   end

   // monitor: pops expectations whenever the DUT presents an output event
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         pop_pend = core_rx_rd;
         addr_smp = tx_buf_addr;
         if (core_rx_rd) chk("rx_pop_when_unempty", core_rx_unempty, 1);
         if ((core_rx_rd || core_tx_wr) && busy) last_evt = cyc;
         if (core_tx_wr) begin
            chk("tx_push_when_unfull", core_tx_unfull, 1);
            if (exp_tx.size() == 0) chk("tx_unexpected", core_tx_data, 24'hxxxxxx);
            else chk("tx_data", core_tx_data, exp_tx.pop_front());
         end
         if (rx_buf_we) begin
            chk("rx_we_with_rd", core_rx_rd, 1);
            if (exp_wr.size() == 0) chk("rx_wr_unexpected", {rx_buf_addr, rx_buf_wdata}, 21'h0);
            else chk("rx_wr", {rx_buf_addr, rx_buf_wdata}, exp_wr.pop_front());
         end
         if (done_valid) begin
            if (exp_done.size() == 0) begin
               chk("done_unexpected", done_valid, 0);
            end else begin
               e = exp_done.pop_front();
               chk("done_code", done_code, e.code);
               chk("done_status", done_status, e.status);
               chk("done_rcvd", done_rcvd, e.rcvd);
               chk("no_pops_after_end", rxq.size(), e.leftover);
               if (e.code == 2'd1) chk("timeout_cycle", cyc, last_evt + TO + 1);
            end
            done_cnt++;
         end
      end
   end

   // reference model: walks the response list by the message rules
   task automatic predict(input logic [15:0] cmd, input logic [23:0] resp[$], input bit push_done);
      int   n, k;
      bit   fin;
      exp_t e;
      logic [23:0] w;
      n = (cmd[4:0] == 5'd0) ? 32 : int'(cmd[4:0]);
      exp_tx.push_back({8'h01, cmd});
      if (!cmd[10]) for (int i = 0; i < n; i++) exp_tx.push_back({8'h00, mem[i]});
      e.status = 16'h0; e.rcvd = 6'd0; e.code = 2'd0; k = 0;
      if (resp.size() == 0) begin
         e.code = 2'd1;
      end else begin
         w = resp[k]; k++;
         if (w[17]) e.code = 2'd2;
         else if (!w[16] || w[15:11] != cmd[15:11]) e.code = 2'd3;
         else begin
            e.status = w[15:0];
            if (cmd[10]) begin
               fin = 1'b0;
               for (int i = 0; i < n && !fin; i++) begin
                  if (k >= resp.size()) begin e.code = 2'd1; fin = 1'b1; end
                  else begin
                     w = resp[k]; k++;
                     if (w[17]) begin e.code = 2'd2; fin = 1'b1; end
                     else if (w[16]) begin e.code = 2'd3; fin = 1'b1; end
                     else begin
                        exp_wr.push_back({5'(i), w[15:0]});
                        e.rcvd = e.rcvd + 6'd1;
                     end
                  end
               end
            end
         end
      end
      e.leftover = resp.size() - k;
      if (push_done) exp_done.push_back(e);
   endtask

   task automatic send_cmd(input logic [15:0] cmd, input int stall);
      int b;
      @(posedge clk); #2;
      cmd_valid = 1'b1; cmd_word = cmd; b = 0;
      @(negedge clk);
      while (!cmd_ready && b < 500) begin @(negedge clk); b++; end
      if (!cmd_ready) bound_fail("cmd_accept");
      stall_cnt = stall;
      @(posedge clk); #2;
      cmd_valid = 1'b0;
   endtask

   task automatic run_msg(input logic [15:0] cmd, input logic [23:0] resp[$], input int dly, input int stall);
      int b, target;
      target = done_cnt + 1;
      predict(cmd, resp, 1'b1);
      send_cmd(cmd, stall);
      b = 0;
      while (exp_tx.size() != 0 && b < 2000) begin @(negedge clk); b++; end
      if (exp_tx.size() != 0) bound_fail("tx_drain");
      repeat (dly) @(posedge clk);
      foreach (resp[i]) rxq.push_back(resp[i]);
      b = 0;
      while (done_cnt < target && b < 4 * TO + 200) begin @(negedge clk); b++; end
      if (done_cnt < target) bound_fail("done_wait");
      b = 0;
      while (rxq.size() != 0 && b < 100) begin @(negedge clk); b++; end
      if (rxq.size() != 0) bound_fail("idle_flush");
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_cmd_ready"}, cmd_ready, 0);
      chk({tag, "_done_valid"}, done_valid, 0);
      chk({tag, "_strobes"}, {core_tx_wr, core_rx_rd, rx_buf_we}, 0);
      chk({tag, "_tx_data"}, core_tx_data, 0);
      chk({tag, "_addrs"}, {tx_buf_addr, rx_buf_addr, rx_buf_wdata}, 0);
      chk({tag, "_done_fields"}, {done_code, done_status, done_rcvd}, 0);
   endtask

   initial begin
      logic [23:0] resp[$];
      logic [15:0] cmd;
      logic [4:0]  rt, nf;
      logic        tr;
      int          n, kind, j, keep, lows, rds, dc;
      logic [23:0] tmp;

      APB_RESET = 1'b1; cmd_valid = 1'b0; cmd_word = 16'h0;
      for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_outputs_zero("reset");
      @(posedge clk); #2 APB_RESET = 1'b0;
      @(negedge clk);
      chk("cmd_ready_after_reset", cmd_ready, 1);

      mem[0] = 16'h1111; mem[1] = 16'h2222;
      resp = '{24'h010800};
      run_msg(16'h0842, resp, 2, 0);

      resp = '{24'h011800, 24'h00000A, 24'h00000B, 24'h00000C};
      run_msg(16'h1C23, resp, 1, 0);

      resp = '{24'h012805};
      for (int i = 0; i < 32; i++) resp.push_back({8'h00, 16'($urandom)});
      run_msg(16'h2C00, resp, 3, 0);

      for (int i = 0; i < 4; i++) mem[i] = 16'h0A00 + 16'(i);
      resp = '{24'h010800};
      run_msg(16'h0804, resp, 0, 10);

      resp.delete();
      run_msg(16'h0C41, resp, 0, 0);
      run_msg(16'h0842, resp, 0, 0);

      resp = '{24'h012800};
      run_msg(16'h0842, resp, 3, 0);

      resp = '{24'h011000, 24'h000111, 24'h000222, 24'h020333, 24'h000444, 24'h000555};
      run_msg(16'h1425, resp, 2, 0);

      // two stale words while idle
      @(posedge clk); #2;
      rxq.push_back(24'h00BEEF); rxq.push_back(24'h011234);
      lows = 0; rds = 0;
      repeat (6) begin
         @(negedge clk);
         if (!cmd_ready && !busy) lows++;
         if (core_rx_rd) rds++;
      end
      chk("stale_cmd_ready_low_cycles", lows, 2);
      chk("stale_pops", rds, 2);
      chk("stale_flushed", rxq.size(), 0);

      for (int m = 0; m < 40; m++) begin
         rt = 5'($urandom); tr = 1'($urandom);
         nf = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 8));
         n  = (nf == 5'd0) ? 32 : int'(nf);
         cmd = {rt, tr, 5'($urandom), nf};
         for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
         resp.delete();
         resp.push_back({8'h01, rt, 11'($urandom)});
         if (tr) for (int i = 0; i < n; i++) resp.push_back({8'h00, 16'($urandom)});
         kind = $urandom_range(0, 9);
         case (kind)
            5: resp[0][17] = 1'b1;
            6: resp[0][15:11] = rt ^ 5'($urandom_range(1, 31));
            7: resp[0][16] = 1'b0;
            8: if (tr) begin
                  j = $urandom_range(1, n);
                  if ($urandom_range(0, 1) == 0) resp[j][17] = 1'b1;
                  else resp[j][16] = 1'b1;
               end
            9: begin
                  keep = $urandom_range(0, resp.size() - 1);
                  while (resp.size() > keep) tmp = resp.pop_back();
               end
            default: ;
         endcase
         run_msg(cmd, resp, $urandom_range(0, 8), ($urandom_range(0, 4) == 0) ? 5 : 0);
      end

      // reset while collecting RT data: message is abandoned without a completion
      resp = '{24'h011800, 24'h000001, 24'h000002, 24'h000003};
      predict(16'h1C28, resp, 1'b0);
      send_cmd(16'h1C28, 0);
      j = 0;
      while (exp_tx.size() != 0 && j < 500) begin @(negedge clk); j++; end
      foreach (resp[i]) rxq.push_back(resp[i]);
      repeat (10) @(posedge clk);
      chk("recv_busy_before_reset", busy, 1);
      dc = done_cnt;
      #1 APB_RESET = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_outputs_zero("midmsg_reset");
      @(posedge clk); #2 APB_RESET = 1'b0;
      @(negedge clk);
      chk("cmd_ready_after_midmsg_reset", cmd_ready, 1);
      repeat (TO + 20) @(negedge clk);
      chk("no_done_after_abort", done_cnt, dc);

      chk("exp_tx_empty", exp_tx.size(), 0);
      chk("exp_wr_empty", exp_wr.size(), 0);
      chk("exp_done_empty", exp_done.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog actual=still_running expected=finished (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
